// File: rtl/player_timers.sv
// Dual per-player chess-clock countdown timers with Fischer increment.
// Times are held as BCD mm:ss; arithmetic is done on small binary fields per digit pair.
module player_timers #(
    parameter int MAX_MIN = 99
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        TICK,
    input  logic        LOAD,
    input  logic [15:0] INIT_TIME,
    input  logic [7:0]  INC_SEC,
    input  logic        Enable_p1,
    input  logic        Enable_p2,
    output logic [15:0] TIME_P1,
    output logic [15:0] TIME_P2,
    output logic        END,
    output logic        LOSER
);

    localparam logic [6:0] MAX_M = 7'(MAX_MIN);

    logic [15:0] time_p1_q, time_p2_q;
    logic [15:0] time_p1_nxt, time_p2_nxt;
    logic        end_q, end_nxt;
    logic        loser_q, loser_nxt;
    logic        en_p1_q, en_p2_q;
    logic        fall_p1, fall_p2;
    logic        dec_p1, dec_p2;
    logic [7:0]  inc_c;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    function automatic logic [15:0] clamp_time(input logic [15:0] t);
        return {clamp_digit(t[15:12], 4'd9), clamp_digit(t[11:8], 4'd9),
                clamp_digit(t[7:4], 4'd5), clamp_digit(t[3:0], 4'd9)};
    endfunction

    function automatic logic [6:0] bcd2_to_bin(input logic [7:0] b);
        return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
    endfunction

    function automatic logic [7:0] bin_to_bcd2(input logic [6:0] v);
        logic [6:0] tens;
        tens = v / 7'd10;
        return {tens[3:0], 4'(v - tens * 7'd10)};
    endfunction

    // Caller guarantees t is above 00:01, so the minute borrow never underflows.
    function automatic logic [15:0] dec_time(input logic [15:0] t);
        logic [6:0] m, s;
        m = bcd2_to_bin(t[15:8]);
        s = bcd2_to_bin(t[7:0]);
        if (s == 7'd0) begin
            s = 7'd59;
            m = m - 7'd1;
        end else begin
            s = s - 7'd1;
        end
        return {bin_to_bcd2(m), bin_to_bcd2(s)};
    endfunction

    function automatic logic [15:0] inc_time(input logic [15:0] t, input logic [7:0] inc);
        logic [6:0] m, s;
        m = bcd2_to_bin(t[15:8]);
        s = bcd2_to_bin(t[7:0]) + bcd2_to_bin(inc);
        if (s >= 7'd60) begin
            s = s - 7'd60;
            m = m + 7'd1;
        end
        if (m > MAX_M) begin
            m = MAX_M;
            s = 7'd59;
        end
        return {bin_to_bcd2(m), bin_to_bcd2(s)};
    endfunction

    assign inc_c   = {clamp_digit(INC_SEC[7:4], 4'd5), clamp_digit(INC_SEC[3:0], 4'd9)};
    assign fall_p1 = en_p1_q & ~Enable_p1;
    assign fall_p2 = en_p2_q & ~Enable_p2;
    assign dec_p1  = TICK & Enable_p1 & ~Enable_p2;
    assign dec_p2  = TICK & Enable_p2 & ~Enable_p1;

    // With both enables high neither dec nor fall can be true, so that case needs no extra term.
    always_comb begin
        time_p1_nxt = time_p1_q;
        time_p2_nxt = time_p2_q;
        end_nxt     = end_q;
        loser_nxt   = loser_q;
        if (!end_q) begin
            if (dec_p1) begin
                if (time_p1_q <= 16'h0001) begin
                    time_p1_nxt = 16'h0000;
                    end_nxt     = 1'b1;
                    loser_nxt   = 1'b0;
                end else begin
                    time_p1_nxt = dec_time(time_p1_q);
                end
            end else if (fall_p1) begin
                time_p1_nxt = inc_time(time_p1_q, inc_c);
            end
            if (dec_p2) begin
                if (time_p2_q <= 16'h0001) begin
                    time_p2_nxt = 16'h0000;
                    end_nxt     = 1'b1;
                    loser_nxt   = 1'b1;
                end else begin
                    time_p2_nxt = dec_time(time_p2_q);
                end
            end else if (fall_p2) begin
                time_p2_nxt = inc_time(time_p2_q, inc_c);
            end
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            time_p1_q <= 16'h0000;
            time_p2_q <= 16'h0000;
            end_q     <= 1'b0;
            loser_q   <= 1'b0;
            en_p1_q   <= 1'b0;
            en_p2_q   <= 1'b0;
        end else if (LOAD) begin
            time_p1_q <= clamp_time(INIT_TIME);
            time_p2_q <= clamp_time(INIT_TIME);
            end_q     <= 1'b0;
            loser_q   <= 1'b0;
            en_p1_q   <= 1'b0;
            en_p2_q   <= 1'b0;
        end else begin
            time_p1_q <= time_p1_nxt;
            time_p2_q <= time_p2_nxt;
            end_q     <= end_nxt;
            loser_q   <= loser_nxt;
            en_p1_q   <= Enable_p1;
            en_p2_q   <= Enable_p2;
        end
    end

    assign TIME_P1 = time_p1_q;
    assign TIME_P2 = time_p2_q;
    assign END     = end_q;
    assign LOSER   = loser_q;

endmodule

// File: doc/player_timers.md
Name: player_timers

Overview:
- Dual per-player countdown timers for the chess clock; the consuming end of the turn-switch enables.
- Takes the two one-hot player enables and a timebase tick, and counts down the active player's time.
- Adds a per-move increment (Fischer) when a player's turn ends.
- Reports expiry on END and LOSER. END feeds back to the turn switch, and the BCD times feed the display multiplexer.

Parameters:
MAX_MIN, 99, saturation limit for minutes on increment (BCD 00..99); time saturates at MAX_MIN:59.

Ports:
CLK  input  1  system clock
CLR  input  1  reset, asynchronous, active-high
TICK  input  1  one-CLK-cycle pulse, once per second
LOAD  input  1  synchronous load of initial time into both players; clears END
INIT_TIME  input  16  BCD mm:ss, {m_tens, m_ones, s_tens, s_ones}
INC_SEC  input  8  BCD increment seconds 00..59
Enable_p1  input  1  player 1 clock running
Enable_p2  input  1  player 2 clock running
TIME_P1  output  16  BCD mm:ss remaining, player 1
TIME_P2  output  16  BCD mm:ss remaining, player 2
END  output  1  sticky: a player's time reached 00:00
LOSER  output  1  valid when END=1: 0 = player 1 flagged, 1 = player 2 flagged

Behaviour:
Clock and reset:
- One clock (CLK); reset CLR is asynchronous and active-high.
- All outputs are registered.
- On CLR: TIME_P1 = TIME_P2 = 16'h0000, END = 0, LOSER = 0, and the edge-detect registers for both enables = 0.

Per-edge priority (highest first): CLR, LOAD, END-freeze, normal operation.

LOAD:
- TIME_P1 and TIME_P2 are loaded with INIT_TIME; END = 0, LOSER = 0; edge-detect registers are cleared.
- LOAD overrides TICK and any increment in the same cycle.
- Out-of-range digits are clamped per digit: any digit >9 becomes 9; s_tens >5 becomes 5.
- 1-cycle latency: the new value is visible on the edge after LOAD is sampled.

END-freeze:
- While END = 1 and LOAD = 0, both times, END and LOSER hold.
- TICK and enables are ignored.

Decrement:
- Applies when TICK = 1, Enable_pX = 1, Enable_p(other) = 0 and END = 0.
- That player's time decrements by 1 s. Borrow: ss 00 -> 59 with minutes -1.
- If the pre-decrement time is 00:01, the time becomes 00:00 and END <= 1 on the same edge, with LOSER set to that player.
- If the pre-decrement time is already 00:00 (e.g. LOAD of 00:00), the time stays 00:00 and END <= 1 with LOSER on the same edge.
- Never wraps below 00:00.

Both enables high:
- Illegal; no decrement and no increment for either player.
- Edge-detect registers still update.

Increment:
- A falling edge of Enable_pX (registered previous value = 1, current = 0) while END = 0 and LOAD = 0 adds INC_SEC to that player's time on that edge.
- Seconds carry: s + inc >= 60 gives s - 60 with minutes +1.
- Minutes saturate: result > MAX_MIN:59 clamps to MAX_MIN:59.
- INC_SEC digits >9 or s_tens >5 are clamped as for LOAD.

Simultaneous events:
- A falling edge on one player and TICK with the other player enabled in the same cycle: both updates apply in that cycle.
- A TICK coinciding with a falling edge on the same player cannot cause a decrement for it, because its enable is now 0.
- Enables from the turn switch are registered; an enable that rises in cycle N is acted on by a TICK in cycle N.

Other rules:
- Internal representation is free (binary or BCD), but the outputs must be valid BCD at all times after reset.
- A CLR mid-game clears everything immediately, without waiting for CLK.

Test Plan:
1. CLR pulse, then LOAD with INIT_TIME=16'h0500 and INC_SEC=8'h00 -> TIME_P1 = TIME_P2 = 16'h0500, END = 0.
2. Enable_p1 = 1, 3 TICKs -> TIME_P1 = 16'h0457, TIME_P2 = 16'h0500.
3. LOAD INIT_TIME=16'h0002, Enable_p2 = 1, 2 TICKs -> TIME_P2 = 16'h0000, and END = 1 with LOSER = 1 on the 2nd TICK edge; a further TICK leaves everything unchanged; LOAD clears END.
4. LOAD INIT_TIME=16'h0055 with INC_SEC=8'h10; Enable_p1 1 -> 0 -> TIME_P1 = 16'h0105. LOAD INIT_TIME=16'h9955; Enable_p1 1 -> 0 -> TIME_P1 = 16'h9959 (saturated).
5. Enable_p1 and Enable_p2 both 1 with TICK -> no change to either time. Then Enable_p1 1 -> 0 in the same cycle as Enable_p2 = 1 with TICK, from 16'h0100/16'h0100 and INC_SEC=8'h05 -> TIME_P1 = 16'h0105, TIME_P2 = 16'h0059.
6. LOAD INIT_TIME=16'hAB7C -> clamped to 16'h9959. Assert CLR asynchronously between CLK edges mid-countdown -> all outputs go to 0 immediately.
